// File: rtl/stream_mux_nch.sv
// rtl/stream_mux_nch.sv - registered N-channel stream multiplexer with fixed-select and round-robin modes
module stream_mux_nch #(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  int               rr_idx;

  // The output register can take a new beat when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Pick the granted channel: direct select, or first valid channel at/after rr_ptr.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_idx      = 0;
    if (!mode) begin
      if (int'(sel) < N_CH) begin
        grant       = sel;
        grant_valid = in_valid[sel];
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest valid channel wins.
      for (int k = N_CH - 1; k >= 0; k--) begin
        rr_idx = (int'(rr_ptr_q) + k) % N_CH;
        if (in_valid[rr_idx]) begin
          grant       = SEL_W'(rr_idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  // One-hot ready to the granted producer only; forced low while in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = in_data[int'(grant)*W +: W];
        out_ch_d   = grant;
      end
    end
    // The pointer only advances past a channel that actually transferred in round-robin mode.
    if (load_en && grant_valid && mode) begin
      rr_ptr_d = (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
    end
  end

  // State registers; reset discards any held beat and restarts arbitration at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_nch.sv
// tb/tb_stream_mux_nch.sv - randomized and directed self-checking bench for stream_mux_nch
module tb_stream_mux_nch;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_ch;
  logic          out_ready;

  // Three-channel instance for the out-of-range select case
  logic          mode3;
  logic [1:0]    sel3;
  logic [2:0]    in_valid3;
  logic [3*W-1:0] in_data3;
  logic [2:0]    in_ready3;
  logic          out_valid3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_ch3;
  logic          out_ready3;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_valid, m_data, m_ch, m_ptr;

  always #5 clk = ~clk;

  stream_mux_nch #(.N_CH(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_nch #(.N_CH(3), .W(W)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Grant as the spec states it: fixed select, or the valid channel closest after the pointer.
  task automatic model_grant(output int g, output int gv);
    int best_d;
    g = 0;
    gv = 0;
    if (!mode) begin
      g = int'(sel);
      gv = (g < N) && in_valid[g];
    end else begin
      best_d = N;
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && ((i - m_ptr + N) % N) < best_d) begin
          best_d = (i - m_ptr + N) % N;
          g = i;
          gv = 1;
        end
      end
    end
  endtask

  // One clock: inputs were set just after the previous edge; check ready mid-cycle, outputs after the edge.
  task automatic cycle();
    int g, gv, load;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    model_grant(g, gv);
    load = (m_valid == 0) || out_ready;
    exp_rdy = '0;
    if (load && gv) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (load) begin
      m_valid = gv;
      if (gv) begin
        m_data = int'(in_data[g*W +: W]);
        m_ch = g;
        if (mode) m_ptr = (g + 1) % N;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_ch", 32'(out_ch), 32'(m_ch));
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  initial begin
    logic [W-1:0] fix_exp [3];
    fix_exp[0] = 8'h11; fix_exp[1] = 8'h22; fix_exp[2] = 8'h33;

    mode = 1'b0; sel = '0; in_valid = '1; in_data = '0; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211; out_ready3 = 1'b1;
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
    rst_n = 1'b0;
    #1;
    check("init_ready", 32'(in_ready), 32'd0);
    check("init_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle after reset stays empty
    in_valid = '0;
    repeat (2) cycle();

    // Mid-traffic reset with a beat held
    in_valid = 4'b0001; set_ch(0, 8'hC3); out_ready = 1'b0;
    cycle();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();
    in_valid = '0; out_ready = 1'b1;
    cycle();

    // Fixed select streaming from ch2 while ch0 also requests
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0101; set_ch(0, 8'hEE); set_ch(2, fix_exp[k]);
      cycle();
      check("fix_data", 32'(out_data), 32'(fix_exp[k]));
      check("fix_ch", 32'(out_ch), 32'd2);
    end

    // Out-of-range select on the three-channel instance
    check("sel3_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    check("sel3_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd1;
    @(posedge clk); #1;
    check("sel1_valid3", 32'(out_valid3), 32'd1);
    check("sel1_data3", 32'(out_data3), 32'h22);

    // Round-robin fairness from a fresh pointer
    do_reset();
    mode = 1'b1; in_valid = '1;
    for (int i = 0; i < N; i++) set_ch(i, 8'hA0 + 8'(i));
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_ch", 32'(out_ch), 32'(k % 4));
      check("rr_data", 32'(out_data), 32'(8'hA0 + 8'(k % 4)));
    end

    // Skip and wrap: drive pointer to 3, then only ch1, then ch0+ch3
    do_reset();
    in_valid = 4'b0100; cycle();
    in_valid = 4'b0010; cycle();
    check("skip_ch", 32'(out_ch), 32'd1);
    in_valid = 4'b1001; cycle();
    check("wrap_ch", 32'(out_ch), 32'd3);
    in_valid = 4'b1001; cycle();
    check("wrap_next_ch", 32'(out_ch), 32'd0);

    // Backpressure: hold 0x5A for four stalled cycles
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; set_ch(1, 8'h5A); out_ready = 1'b1;
    cycle();
    mode = 1'b1; in_valid = '1; out_ready = 1'b0;
    for (int i = 0; i < N; i++) set_ch(i, 8'h40 + 8'(i));
    repeat (4) begin
      cycle();
      check("stall_data", 32'(out_data), 32'h5A);
    end
    out_ready = 1'b1; in_valid = 4'b0010; set_ch(1, 8'h77);
    cycle();
    check("drain_data", 32'(out_data), 32'h77);
    check("drain_valid", 32'(out_valid), 32'd1);

    // Mode switch: pointer now 2, fixed beats on ch0, then round-robin resumes at ch2
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    repeat (2) cycle();
    mode = 1'b1; in_valid = '1;
    cycle();
    check("resume_ch", 32'(out_ch), 32'd2);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      mode = 1'($urandom);
      sel = SW'($urandom);
      in_valid = N'($urandom);
      in_data = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
